servo_pwm: RTL and testbench

Downstream stage of the servo tester: converts a pulse-length command in microseconds into a standard hobby-servo control waveform on one pin. A clock prescaler generates a 1 µs tick and a frame counter sets the repetition period (20 ms by default). The pulse command is sampled only at frame boundaries, so every pulse on the pin is glitch-free and whole. The debounced up/down adjust logic drives `pulse_len`, and `CONTROL_PIN` goes to the board header.

---
 rtl/servo_pwm.sv | 98 +++++++++
 tb/tb_servo_pwm.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/servo_pwm.sv
// Hobby-servo PWM: 1 us prescaled tick, FRAME_US frame, pulse length sampled at frame boundaries; pin registered (1-cycle latency).
// Define SERVO_PWM_CLAMP_EN to limit the sampled length to MIN_US..MAX_US and report it on clamped.
module servo_pwm #(
   parameter int unsigned CLK_MHZ  = 100,
   parameter int unsigned FRAME_US = 20000,
   parameter int unsigned MIN_US   = 1000,
   parameter int unsigned MAX_US   = 2000,
   parameter int unsigned RESET_US = 1500
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [15:0] pulse_len,
   input  logic        enable,
   output logic        CONTROL_PIN,
   output logic        frame_start,
   output logic        clamped
);

`ifdef SERVO_PWM_CLAMP_EN
   localparam bit CLAMP_EN = 1'b1;
`else
   localparam bit CLAMP_EN = 1'b0;
`endif

   localparam int unsigned PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_MHZ - 1);
   localparam logic [15:0]   US_LAST   = 16'(FRAME_US - 1);
   localparam logic [15:0]   MIN_LEN   = 16'(MIN_US);
   localparam logic [15:0]   MAX_LEN   = 16'(MAX_US);
   localparam logic [15:0]   RESET_LEN = 16'(RESET_US);

   logic [PW-1:0] pre_q, pre_d;
   logic [15:0]   us_q, us_d;
   logic [15:0]   len_q, len_d;
   logic          pin_q, pin_d;
   logic          fs_q, fs_d;
   logic          clamped_q, clamped_d;

   logic          tick;
   logic          boundary;
   logic [15:0]   samp_len;
   logic          samp_clamp;

   // Clamp guards against wrapped values from the adjust logic upstream.
   always_comb begin
      samp_len   = pulse_len;
      samp_clamp = 1'b0;
      if (CLAMP_EN && (pulse_len < MIN_LEN)) begin
         samp_len   = MIN_LEN;
         samp_clamp = 1'b1;
      end else if (CLAMP_EN && (pulse_len > MAX_LEN)) begin
         samp_len   = MAX_LEN;
         samp_clamp = 1'b1;
      end
   end

   assign tick     = (pre_q == PRE_LAST);
   assign boundary = tick && (us_q == US_LAST);

   always_comb begin
      pre_d     = tick ? '0 : pre_q + 1'b1;
      us_d      = us_q;
      len_d     = len_q;
      clamped_d = clamped_q;
      if (boundary) begin
         us_d      = '0;
         len_d     = samp_len;
         clamped_d = samp_clamp;
      end else if (tick) begin
         us_d = us_q + 16'd1;
      end
      fs_d  = boundary;
      pin_d = enable && (us_q < len_q);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pre_q     <= '0;
         us_q      <= '0;
         len_q     <= RESET_LEN;
         pin_q     <= 1'b0;
         fs_q      <= 1'b0;
         clamped_q <= 1'b0;
      end else begin
         pre_q     <= pre_d;
         us_q      <= us_d;
         len_q     <= len_d;
         pin_q     <= pin_d;
         fs_q      <= fs_d;
         clamped_q <= clamped_d;
      end
   end

   assign CONTROL_PIN = pin_q;
   assign frame_start = fs_q;
   assign clamped     = clamped_q;

endmodule

// File: tb/tb_servo_pwm.sv
// Directed bench for servo_pwm with CLK_MHZ=2, FRAME_US=100, MIN_US=10, MAX_US=50, RESET_US=30 (200-cycle frames).
module tb_servo_pwm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] pulse_len;
   logic        enable;
   logic        pin;
   logic        fs;
   logic        clamped;

   int checks = 0;
   int errors = 0;

   logic pin_hist [1:200];
   logic cl_hist  [1:200];
   int   hc, fs_cnt, fs_pos;

`ifdef SERVO_PWM_CLAMP_EN
   localparam logic [15:0] LEN_A = 16'd5;
   localparam int          HC_A  = 20;
   localparam logic        CL_A  = 1'b1;
   localparam logic [15:0] LEN_B = 16'd65436;
   localparam int          HC_B  = 100;
   localparam logic        CL_B  = 1'b1;
`else
   localparam logic [15:0] LEN_A = 16'd0;
   localparam int          HC_A  = 0;
   localparam logic        CL_A  = 1'b0;
   localparam logic [15:0] LEN_B = 16'd100;
   localparam int          HC_B  = 200;
   localparam logic        CL_B  = 1'b0;
`endif

   servo_pwm #(
      .CLK_MHZ (2),
      .FRAME_US(100),
      .MIN_US  (10),
      .MAX_US  (50),
      .RESET_US(30)
   ) dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .pulse_len  (pulse_len),
      .enable     (enable),
      .CONTROL_PIN(pin),
      .frame_start(fs),
      .clamped    (clamped)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Runs one 200-cycle frame, sampling 1 time unit after each edge; events fire after sample i.
   task automatic run_frame(input int chg_at, input logic [15:0] chg_val,
                            input int en_off, input int en_on);
      hc = 0; fs_cnt = 0; fs_pos = 0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;
         pin_hist[i] = pin;
         cl_hist[i]  = clamped;
         if (pin === 1'b1) hc++;
         if (fs === 1'b1) begin fs_cnt++; fs_pos = i; end
         if (i == chg_at) pulse_len = chg_val;
         if (i == en_off) enable = 1'b0;
         if (i == en_on)  enable = 1'b1;
      end
   endtask

   task automatic check_frame(input string tag, input int exp_hc);
      check({tag, "_high"}, hc, exp_hc);
      check({tag, "_fs_cnt"}, fs_cnt, 1);
      check({tag, "_fs_pos"}, fs_pos, 200);
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b1; pulse_len = 16'd30;
      #1;
      check("rst_pin", pin, 0);
      check("rst_fs", fs, 0);
      check("rst_clamped", clamped, 0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_pin_clocked", pin, 0);
      @(negedge clk) rst_n = 1'b1;

      // Frame 1: reset length 30 -> 60 high; mid-frame write of 20 applies next frame.
      run_frame(100, 16'd20, 0, 0);
      check_frame("f1", 60);
      check("f1_first_high", pin_hist[1], 1);
      check("f1_last_high", pin_hist[60], 1);
      check("f1_first_low", pin_hist[61], 0);
      check("f1_clamped", cl_hist[100], 0);

      // Frame 2: 40 high; write of 40 during the pulse must not stretch it.
      run_frame(10, 16'd40, 0, 0);
      check_frame("f2", 40);
      check("f2_fall", pin_hist[41], 0);

      // Frame 3: 80 high; value written just before the boundary edge is sampled.
      run_frame(199, LEN_A, 0, 0);
      check_frame("f3", 80);

      run_frame(199, LEN_B, 0, 0);
      check_frame("f4_lenA", HC_A);
      check("f4_clamped_start", cl_hist[1], CL_A);
      check("f4_clamped_end", cl_hist[199], CL_A);

      run_frame(199, 16'd30, 0, 0);
      check_frame("f5_lenB", HC_B);
      check("f5_clamped", cl_hist[100], CL_B);

      // Frame 6: enable off at 20 (pin falls at 21), back on at 40 while us=20<30.
      run_frame(0, 16'd30, 20, 40);
      check_frame("f6_enable", 40);
      check("f6_clamped", cl_hist[50], 0);
      check("f6_before_off", pin_hist[20], 1);
      check("f6_after_off", pin_hist[21], 0);
      check("f6_still_off", pin_hist[40], 0);
      check("f6_after_on", pin_hist[41], 1);
      check("f6_end_pulse", pin_hist[61], 0);

      // Frame 7: reset 25 cycles into the pulse drops the pin without a clock edge.
      repeat (25) @(posedge clk);
      #1;
      check("f7_pre_reset_pin", pin, 1);
      #2 rst_n = 1'b0;
      #1;
      check("f7_async_pin", pin, 0);
      check("f7_async_fs", fs, 0);
      pulse_len = 16'd45;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      run_frame(0, 16'd45, 0, 0);
      check_frame("f8_after_reset", 60);
      check("f8_first_high", pin_hist[1], 1);

      run_frame(0, 16'd45, 0, 0);
      check_frame("f9_len45", 90);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
